// File: rtl/cache_line_arbiter.sv
// cache_line_arbiter
//   Arbitrates I-cache line fills and D-cache line fills/writebacks onto one
//   shared physical-memory line port. One transaction in flight at a time;
//   grant and completion are both registered, so every output is a flop.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   icache_read/address          I-cache line read request (held until resp)
//   icache_rdata/resp            I-cache fill data and one-cycle completion
//   dcache_read/write/address    D-cache fill / writeback request
//   dcache_wdata                 D-cache writeback data
//   dcache_rdata/resp            D-cache fill data and one-cycle completion
//   pmem_read/write/address      shared-port request (address line-aligned)
//   pmem_wdata                   shared-port write data
//   pmem_rdata/resp              shared-port read data and completion
//
// Build option
//   CACHE_ARB_RR_EN  round-robin arbitration on conflicts (default: D over I)

module cache_line_arbiter #(
  parameter int LINE_WIDTH  = 256,
  parameter int ADDR_WIDTH  = 32,
  parameter int OFFSET_BITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  icache_read,
  input  logic [ADDR_WIDTH-1:0] icache_address,
  output logic [LINE_WIDTH-1:0] icache_rdata,
  output logic                  icache_resp,
  input  logic                  dcache_read,
  input  logic                  dcache_write,
  input  logic [ADDR_WIDTH-1:0] dcache_address,
  input  logic [LINE_WIDTH-1:0] dcache_wdata,
  output logic [LINE_WIDTH-1:0] dcache_rdata,
  output logic                  dcache_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [2:0] {IDLE, SERVE_I, SERVE_D, DONE_I, DONE_D} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {ADDR_WIDTH{1'b1}} << OFFSET_BITS;

  state_t                state, state_d;
  logic                  pmem_read_d, pmem_write_d;
  logic                  icache_resp_d, dcache_resp_d;
  logic [ADDR_WIDTH-1:0] pmem_address_d;
  logic [LINE_WIDTH-1:0] pmem_wdata_d, icache_rdata_d, dcache_rdata_d;

  logic i_req, d_req, grant_d;

  assign i_req = icache_read;
  assign d_req = dcache_read | dcache_write;

`ifdef CACHE_ARB_RR_EN
  // last_grant: 1 = D-cache won the previous grant, 0 = I-cache.
  logic last_grant, last_grant_d;
  // On a conflict the side not granted last time wins.
  assign grant_d = d_req & (~i_req | ~last_grant);
`else
  assign grant_d = d_req;
`endif

  always_comb begin
    state_d        = state;
    pmem_read_d    = pmem_read;
    pmem_write_d   = pmem_write;
    pmem_address_d = pmem_address;
    pmem_wdata_d   = pmem_wdata;
    icache_resp_d  = icache_resp;
    dcache_resp_d  = dcache_resp;
    icache_rdata_d = icache_rdata;
    dcache_rdata_d = dcache_rdata;
`ifdef CACHE_ARB_RR_EN
    last_grant_d   = last_grant;
`endif
    case (state)
      IDLE: begin
        if (grant_d) begin
          // read+write together is treated as a writeback
          pmem_write_d   = dcache_write;
          pmem_read_d    = ~dcache_write;
          pmem_address_d = dcache_address & ADDR_MASK;
          pmem_wdata_d   = dcache_wdata;
          state_d        = SERVE_D;
`ifdef CACHE_ARB_RR_EN
          last_grant_d   = 1'b1;
`endif
        end else if (i_req) begin
          pmem_read_d    = 1'b1;
          pmem_write_d   = 1'b0;
          pmem_address_d = icache_address & ADDR_MASK;
          state_d        = SERVE_I;
`ifdef CACHE_ARB_RR_EN
          last_grant_d   = 1'b0;
`endif
        end
      end
      SERVE_I: begin
        if (pmem_resp) begin
          pmem_read_d    = 1'b0;
          pmem_write_d   = 1'b0;
          icache_rdata_d = pmem_rdata;
          icache_resp_d  = 1'b1;
          state_d        = DONE_I;
        end
      end
      SERVE_D: begin
        if (pmem_resp) begin
          pmem_read_d   = 1'b0;
          pmem_write_d  = 1'b0;
          if (!pmem_write) dcache_rdata_d = pmem_rdata;
          dcache_resp_d = 1'b1;
          state_d       = DONE_D;
        end
      end
      // One dead cycle so the requester can drop its request before the
      // next arbitration.
      DONE_I: begin
        icache_resp_d = 1'b0;
        state_d       = IDLE;
      end
      DONE_D: begin
        dcache_resp_d = 1'b0;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      icache_resp  <= 1'b0;
      dcache_resp  <= 1'b0;
      icache_rdata <= '0;
      dcache_rdata <= '0;
`ifdef CACHE_ARB_RR_EN
      last_grant   <= 1'b0;
`endif
    end else begin
      state        <= state_d;
      pmem_read    <= pmem_read_d;
      pmem_write   <= pmem_write_d;
      pmem_address <= pmem_address_d;
      pmem_wdata   <= pmem_wdata_d;
      icache_resp  <= icache_resp_d;
      dcache_resp  <= dcache_resp_d;
      icache_rdata <= icache_rdata_d;
      dcache_rdata <= dcache_rdata_d;
`ifdef CACHE_ARB_RR_EN
      last_grant   <= last_grant_d;
`endif
    end
  end

endmodule

// File: tb/tb_cache_line_arbiter.sv
// Directed bench for cache_line_arbiter: reset values, I read, D writeback,
// conflicting requests (fixed priority or round-robin), illegal read+write,
// reset mid-transaction, stray pmem_resp in IDLE.
module tb_cache_line_arbiter;
  localparam int LW = 256;
  localparam int AW = 32;
`ifdef CACHE_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          icache_read, dcache_read, dcache_write;
  logic [AW-1:0] icache_address, dcache_address;
  logic [LW-1:0] icache_rdata, dcache_rdata, dcache_wdata;
  logic          icache_resp, dcache_resp;
  logic          pmem_read, pmem_write, pmem_resp;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata, pmem_rdata;

  int checks = 0;
  int errors = 0;
  int i_pulses = 0;
  int d_pulses = 0;
  logic [LW-1:0] exp_irdata, exp_drdata;

  cache_line_arbiter dut (
    .clk(clk), .rst(rst),
    .icache_read(icache_read), .icache_address(icache_address),
    .icache_rdata(icache_rdata), .icache_resp(icache_resp),
    .dcache_read(dcache_read), .dcache_write(dcache_write),
    .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
    .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  // Count resp cycles so duplicated or missing pulses show up.
  always @(posedge clk) begin
    if (icache_resp) i_pulses <= i_pulses + 1;
    if (dcache_resp) d_pulses <= d_pulses + 1;
  end

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Called just after the grant edge; answers after lat cycles of pmem request.
  task automatic serve(input bit is_d, input bit is_wr, input logic [AW-1:0] exp_addr,
                       input logic [LW-1:0] data, input int lat);
    chk_b("pmem_read_on_grant", pmem_read, !is_wr);
    chk_b("pmem_write_on_grant", pmem_write, is_wr);
    chk("pmem_address", LW'(pmem_address), LW'(exp_addr));
    repeat (lat - 1) tick;
    chk_b("pmem_req_held", pmem_read | pmem_write, 1'b1);
    chk("pmem_address_held", LW'(pmem_address), LW'(exp_addr));
    pmem_resp = 1'b1;
    pmem_rdata = data;
    tick;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    if (!is_wr) begin
      if (is_d) exp_drdata = data;
      else      exp_irdata = data;
    end
    chk_b("icache_resp", icache_resp, !is_d);
    chk_b("dcache_resp", dcache_resp, is_d);
    chk_b("pmem_req_dropped", pmem_read | pmem_write, 1'b0);
    chk("icache_rdata", icache_rdata, exp_irdata);
    chk("dcache_rdata", dcache_rdata, exp_drdata);
    if (is_d) begin
      dcache_read = 1'b0;
      dcache_write = 1'b0;
    end else begin
      icache_read = 1'b0;
    end
    tick;
    chk_b("resp_single_cycle", icache_resp | dcache_resp, 1'b0);
    chk_b("no_grant_in_done", pmem_read | pmem_write, 1'b0);
  endtask

  initial begin
    bit            gd;
    bit            last_gd;
    logic [31:0]   dk;
    int            i0, d0;

    rst = 1'b1;
    icache_read = 1'b0; dcache_read = 1'b0; dcache_write = 1'b0;
    icache_address = '0; dcache_address = '0; dcache_wdata = '0;
    pmem_resp = 1'b0; pmem_rdata = '0;
    exp_irdata = '0; exp_drdata = '0;
    tick; tick;
    chk_b("rst_pmem_read", pmem_read, 1'b0);
    chk_b("rst_pmem_write", pmem_write, 1'b0);
    chk_b("rst_icache_resp", icache_resp, 1'b0);
    chk_b("rst_dcache_resp", dcache_resp, 1'b0);
    chk("rst_pmem_address", LW'(pmem_address), '0);
    chk("rst_pmem_wdata", pmem_wdata, '0);
    chk("rst_icache_rdata", icache_rdata, '0);
    chk("rst_dcache_rdata", dcache_rdata, '0);
    rst = 1'b0;
    tick;

    // I-only read; address changes during SERVE must be ignored
    icache_read = 1'b1;
    icache_address = 32'h0000_1234;
    tick;
    icache_address = 32'hFFFF_FFFF;
    serve(1'b0, 1'b0, 32'h0000_1220, {8{32'hCAFE_0001}}, 3);

    // D writeback with A5 pattern; wdata change during SERVE ignored
    dcache_write = 1'b1;
    dcache_address = 32'h8000_0040;
    dcache_wdata = {32{8'hA5}};
    tick;
    dcache_wdata = '0;
    chk("wb_pmem_wdata", pmem_wdata, {32{8'hA5}});
    tick;
    chk("wb_pmem_wdata_held", pmem_wdata, {32{8'hA5}});
    serve(1'b1, 1'b1, 32'h8000_0040, {8{32'hDEAD_BEEF}}, 1);

    // Conflicts: a served requester re-raises in IDLE, so both are pending
    // at every arbitration. Fixed priority serves D every time; round-robin
    // alternates D, I, D, I.
    rst = 1'b1;
    tick;
    rst = 1'b0;
    exp_irdata = '0;
    exp_drdata = '0;
    i0 = i_pulses;
    d0 = d_pulses;
    icache_read = 1'b1; icache_address = 32'h1000_0010;
    dcache_read = 1'b1; dcache_address = 32'h2000_003C;
    tick;
    last_gd = 1'b0;
    for (int k = 0; k < 4; k++) begin
      gd = RR ? (k % 2 == 0) : 1'b1;
      dk = 32'h1111_0000 + 32'(k);
      serve(gd, 1'b0, gd ? 32'h2000_0020 : 32'h1000_0000, {8{dk}}, 1);
      if (k < 3) begin
        if (gd) dcache_read = 1'b1;
        else    icache_read = 1'b1;
      end
      last_gd = gd;
      tick;
    end
    serve(!last_gd, 1'b0, !last_gd ? 32'h2000_0020 : 32'h1000_0000, {8{32'h5555_AAAA}}, 2);
    chk("conflict_i_pulses", LW'(i_pulses - i0), RR ? LW'(2) : LW'(1));
    chk("conflict_d_pulses", LW'(d_pulses - d0), RR ? LW'(3) : LW'(4));

    // read+write together behaves as a writeback
    dcache_read = 1'b1; dcache_write = 1'b1;
    dcache_address = 32'h0000_0ABC;
    dcache_wdata = {8{32'h0F0F_0F0F}};
    tick;
    chk("rw_pmem_wdata", pmem_wdata, {8{32'h0F0F_0F0F}});
    serve(1'b1, 1'b1, 32'h0000_0AA0, {8{32'h1234_5678}}, 2);

    // reset while in SERVE_D
    dcache_read = 1'b1;
    dcache_address = 32'h0000_4444;
    tick;
    chk_b("pre_rst_pmem_read", pmem_read, 1'b1);
    tick;
    rst = 1'b1;
    tick;
    chk_b("midrst_pmem_read", pmem_read, 1'b0);
    chk_b("midrst_dcache_resp", dcache_resp, 1'b0);
    chk("midrst_pmem_address", LW'(pmem_address), '0);
    rst = 1'b0;
    exp_irdata = '0;
    exp_drdata = '0;
    tick;
    serve(1'b1, 1'b0, 32'h0000_4440, {8{32'h9ABC_DEF0}}, 2);

    // stray pmem_resp in IDLE
    pmem_resp = 1'b1;
    pmem_rdata = {8{32'h7777_7777}};
    tick;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    chk_b("stray_icache_resp", icache_resp, 1'b0);
    chk_b("stray_dcache_resp", dcache_resp, 1'b0);
    chk_b("stray_pmem_read", pmem_read, 1'b0);
    chk("stray_dcache_rdata", dcache_rdata, exp_drdata);
    tick;
    chk_b("stray_resp_later", icache_resp | dcache_resp, 1'b0);
    dcache_read = 1'b1;
    dcache_address = 32'h0000_9000;
    tick;
    serve(1'b1, 1'b0, 32'h0000_9000, {8{32'h0BAD_F00D}}, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
